// File: rtl/julia_engine_if.sv
// rtl/julia_engine_if.sv - pixel write handshake between julia_engine and the framebuffer writer
interface julia_engine_if;
  logic        o_Valid;
  logic        i_Ready;
  logic [18:0] o_Addr;
  logic [15:0] o_Data;

  modport master (output o_Valid, output o_Addr, output o_Data, input i_Ready);
  modport slave  (input o_Valid, input o_Addr, input o_Data, output i_Ready);
endinterface

// File: rtl/julia_engine.sv
// rtl/julia_engine.sv - Julia set escape-time renderer streaming RGB565 pixels in raster order
module julia_engine #(
  parameter int H_RES    = 800,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 63
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_Start,
  input  logic signed [15:0] i_CRe,
  input  logic signed [15:0] i_CIm,
  output logic               o_Busy,
  output logic               o_Done,
  julia_engine_if.master     pix
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_OUTPUT, S_DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);
  localparam logic [5:0] N_CAP  = 6'(MAX_ITER);

  state_t             state, state_nx;
  logic [9:0]         x;
  logic [8:0]         y;
  logic [5:0]         n;
  logic signed [15:0] zr, zi, c_re, c_im;
  logic signed [31:0] zr_w, zi_w, rr, ii, ri;
  logic [32:0]        mag;
  logic signed [15:0] zr_init, zi_init, zr_upd, zi_upd;
  logic               escape, last_px, xfer;

  // z is Q4.12; products are Q8.24, so 4.0 in mag is 1<<26
  always_comb begin
    zr_w    = {{16{zr[15]}}, zr};
    zi_w    = {{16{zi[15]}}, zi};
    rr      = zr_w * zr_w;
    ii      = zi_w * zi_w;
    ri      = zr_w * zi_w;
    mag     = {1'b0, rr} + {1'b0, ii};
    escape  = (mag > 33'h4000000) || (n == N_CAP);
    zr_upd  = 16'((rr - ii) >>> 12) + c_re;
    zi_upd  = 16'(ri >>> 11) + c_im;
    zr_init = 16'(($signed({1'b0, x}) - H_RES / 2) * 16);
    zi_init = 16'(($signed({1'b0, y}) - V_RES / 2) * 16);
    last_px = (x == X_LAST) && (y == Y_LAST);
    xfer    = (state == S_OUTPUT) && pix.i_Ready;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (i_Start) state_nx = S_INIT;
      S_INIT:   state_nx = S_ITER;
      S_ITER:   if (escape) state_nx = S_OUTPUT;
      S_OUTPUT: if (pix.i_Ready) state_nx = last_px ? S_DONE : S_INIT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // n is left untouched on escape, so it doubles as the latched result in OUTPUT
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      x    <= '0;
      y    <= '0;
      n    <= '0;
      zr   <= '0;
      zi   <= '0;
      c_re <= '0;
      c_im <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (i_Start) begin
          x    <= '0;
          y    <= '0;
          c_re <= i_CRe;
          c_im <= i_CIm;
        end
        S_INIT: begin
          zr <= zr_init;
          zi <= zi_init;
          n  <= '0;
        end
        S_ITER: if (!escape) begin
          zr <= zr_upd;
          zi <= zi_upd;
          n  <= n + 6'd1;
        end
        S_OUTPUT: if (xfer) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? 9'd0 : y + 9'd1;
          end else begin
            x <= x + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pix.o_Valid = (state == S_OUTPUT);
    pix.o_Addr  = '0;
    pix.o_Data  = '0;
    o_Busy      = (state != S_IDLE);
    o_Done      = (state == S_DONE);
    if (state == S_OUTPUT) begin
      pix.o_Addr = {y, x};
      pix.o_Data = (n == N_CAP) ? 16'h0000 : {n[4:0], n, ~n[4:0]};
    end
  end
endmodule

// File: tb/tb_julia_engine.sv
// tb/tb_julia_engine.sv - scoreboard bench for julia_engine on three frame geometries
module tb_julia_engine;
  typedef struct {logic [18:0] addr; logic [15:0] data;} px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic               rst_a, rst_b, rst_c, start_a, start_b, start_c;
  logic signed [15:0] cre_a, cim_a, cre_b, cim_b, cre_c, cim_c;
  logic               busy_a, busy_b, busy_c, done_a, done_b, done_c;
  julia_engine_if if_a();
  julia_engine_if if_b();
  julia_engine_if if_c();

  julia_engine dut_a (.i_CLK(clk), .i_RST_N(rst_a), .i_Start(start_a), .i_CRe(cre_a),
                      .i_CIm(cim_a), .o_Busy(busy_a), .o_Done(done_a), .pix(if_a));
  julia_engine #(.H_RES(40), .V_RES(30)) dut_b (.i_CLK(clk), .i_RST_N(rst_b), .i_Start(start_b),
                      .i_CRe(cre_b), .i_CIm(cim_b), .o_Busy(busy_b), .o_Done(done_b), .pix(if_b));
  julia_engine #(.H_RES(16), .V_RES(8)) dut_c (.i_CLK(clk), .i_RST_N(rst_c), .i_Start(start_c),
                      .i_CRe(cre_c), .i_CIm(cim_c), .o_Busy(busy_c), .o_Done(done_c), .pix(if_c));

  px_t q_a[$], q_b[$], q_c[$];
  px_t ea, eb, ec;
  int xfer_a = 0, xfer_b = 0, xfer_c = 0, last_c = 0, done_cnt_b = 0;
  logic [18:0] last_addr_b = '0, first_addr_b = '1;
  logic hold_b = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic int wrap16(int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic logic [15:0] model_px(int x, int y, int h, int v, int cre, int cim);
    int zr, zi, rr, ii, ri, n;
    longint mag;
    logic [5:0] nb;
    zr = wrap16((x - h / 2) * 16);
    zi = wrap16((y - v / 2) * 16);
    for (n = 0; n < 63; n++) begin
      rr  = zr * zr;
      ii  = zi * zi;
      ri  = zr * zi;
      mag = longint'(rr) + longint'(ii);
      if (mag > 64'sh4000000) break;
      zr = wrap16(((rr - ii) >>> 12) + cre);
      zi = wrap16((ri >>> 11) + cim);
    end
    nb = 6'(n);
    return (n == 63) ? 16'h0000 : {nb[4:0], nb, ~nb[4:0]};
  endfunction

  task automatic fill(input int which, input int h, input int v, input int cre, input int cim);
    px_t p;
    for (int yy = 0; yy < v; yy++)
      for (int xx = 0; xx < h; xx++) begin
        p.addr = {9'(yy), 10'(xx)};
        p.data = model_px(xx, yy, h, v, cre, cim);
        if (which == 1) q_b.push_back(p);
        else q_c.push_back(p);
      end
  endtask

  always @(negedge clk) begin
    if (if_a.o_Valid && if_a.i_Ready) begin
      xfer_a++;
      if (q_a.size() == 0) check("a_unexpected_pixel", if_a.o_Addr, 32'hFFFFFFFF);
      else begin
        ea = q_a.pop_front();
        check("a_addr", if_a.o_Addr, ea.addr);
        check("a_data", if_a.o_Data, ea.data);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) done_cnt_b++;
    if (if_b.o_Valid && if_b.i_Ready) begin
      xfer_b++;
      if (xfer_b == 1) first_addr_b = if_b.o_Addr;
      last_addr_b = if_b.o_Addr;
      if (q_b.size() == 0) check("b_unexpected_pixel", if_b.o_Addr, 32'hFFFFFFFF);
      else begin
        eb = q_b.pop_front();
        check("b_addr", if_b.o_Addr, eb.addr);
        check("b_data", if_b.o_Data, eb.data);
      end
    end
  end

  // centre pixel of the 16x8 frame has z0=0 and c=0: capped, so INIT + 64 ITER + OUTPUT
  always @(negedge clk) begin
    if (if_c.o_Valid && if_c.i_Ready) begin
      xfer_c++;
      if (q_c.size() == 0) check("c_unexpected_pixel", if_c.o_Addr, 32'hFFFFFFFF);
      else begin
        ec = q_c.pop_front();
        check("c_addr", if_c.o_Addr, ec.addr);
        check("c_data", if_c.o_Data, ec.data);
      end
      if (if_c.o_Addr == {9'd4, 10'd8}) begin
        check("c_centre_data", if_c.o_Data, 16'h0000);
        check("c_centre_cycles", cyc - last_c, 66);
      end
      last_c = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if_b.i_Ready = hold_b ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b1; start_b = 1'b0; start_c = 1'b0;
    cre_a = '0; cim_a = '0; cre_b = 16'sd4096; cim_b = '0; cre_c = '0; cim_c = '0;
    if_a.i_Ready = 1'b0; if_c.i_Ready = 1'b1;

    // reset held with start high: everything quiet
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_rst_valid", if_a.o_Valid, 0);
      check("a_rst_addr_data", {if_a.o_Addr, if_a.o_Data}, 0);
      check("a_rst_busy_done", {busy_a, done_a}, 0);
    end
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    q_a.push_back('{addr: 19'h0, data: 16'h083E});
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < 200 && !if_a.o_Valid; i++) @(negedge clk);
    check("a_first_valid", if_a.o_Valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a_stall_valid", if_a.o_Valid, 1);
      check("a_stall_addr", if_a.o_Addr, 19'h0);
      check("a_stall_data", if_a.o_Data, 16'h083E);
    end
    @(posedge clk); #1 if_a.i_Ready = 1'b1;
    @(posedge clk); #1 if_a.i_Ready = 1'b0;
    @(negedge clk);
    check("a_one_transfer", xfer_a, 1);
    check("a_valid_after_xfer", if_a.o_Valid, 0);
    rst_a = 1'b0;

    // 16x8 frame, c=0, ready always high
    fill(2, 16, 8, 0, 0);
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    for (int i = 0; i < 20000 && !done_c; i++) @(negedge clk);
    check("c_done_seen", done_c, 1);
    check("c_transfers", xfer_c, 128);
    check("c_queue_empty", q_c.size(), 0);

    // 40x30 frame, c=1.0, random ready
    fill(1, 40, 30, 4096, 0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < 40000 && !done_b; i++) @(negedge clk);
    check("b_done_seen", done_b, 1);
    check("b_transfers", xfer_b, 1200);
    check("b_last_addr", last_addr_b, {9'd29, 10'd39});
    check("b_queue_empty", q_b.size(), 0);
    @(negedge clk);
    check("b_busy_after_done", busy_b, 0);
    repeat (3) @(negedge clk);
    check("b_done_pulses", done_cnt_b, 1);

    // second frame: stray start mid-frame, then reset around pixel 1000
    xfer_b = 0;
    fill(1, 40, 30, 4096, 0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (20) @(posedge clk);
    #1 cre_b = '0; cim_b = 16'sd100; start_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_b = 1'b0;
    check("b_busy_after_stray_start", busy_b, 1);
    for (int i = 0; i < 40000 && xfer_b < 1000; i++) @(negedge clk);
    check("b_reached_1000", xfer_b >= 1000, 1);
    hold_b = 1'b1;
    for (int i = 0; i < 200 && !if_b.o_Valid; i++) @(negedge clk);
    check("b_valid_before_reset", if_b.o_Valid, 1);
    #2 rst_b = 1'b0;
    #1;
    check("b_async_valid_drop", if_b.o_Valid, 0);
    check("b_rst_addr_data", {if_b.o_Addr, if_b.o_Data}, 0);
    check("b_rst_busy_done", {busy_b, done_b}, 0);
    q_b.delete();
    xfer_b = 0;
    first_addr_b = '1;
    cre_b = 16'sd4096; cim_b = '0;
    fill(1, 40, 30, 4096, 0);
    @(posedge clk); #1 rst_b = 1'b1; hold_b = 1'b0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < 2000 && xfer_b < 3; i++) @(negedge clk);
    check("b_restart_transfers", xfer_b >= 3, 1);
    check("b_restart_first_addr", first_addr_b, 19'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
